// File: rtl/instr_mem_loader_pkg.sv
// ============================================================================
//  Module   : instr_mem_loader_pkg
//  Brief    : Shared widths, HALT marker and loader FSM state encodings.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NB_BITS
`define NB_BITS 32
`endif

`ifndef RAM_FETCH_DEPTH
`define RAM_FETCH_DEPTH 10
`endif

`ifndef HALT_INSTR
`define HALT_INSTR 32'hFFFF_FFFF
`endif

package instr_mem_loader_pkg;

  localparam int C_NB_BITS   = `NB_BITS;
  localparam int C_RAM_DEPTH = `RAM_FETCH_DEPTH;
  localparam logic [C_NB_BITS-1:0] C_HALT_WORD = `HALT_INSTR;

  // Loader FSM encodings
  localparam logic [2:0] C_ST_IDLE  = 3'd0;
  localparam logic [2:0] C_ST_LOAD  = 3'd1;
  localparam logic [2:0] C_ST_WRITE = 3'd2;
  localparam logic [2:0] C_ST_DONE  = 3'd3;
  localparam logic [2:0] C_ST_ERROR = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_LOAD  = C_ST_LOAD,
    ST_WRITE = C_ST_WRITE,
    ST_DONE  = C_ST_DONE,
    ST_ERROR = C_ST_ERROR
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
//  Module   : instr_mem_loader
//  Brief    : Assembles a big-endian byte stream into words and writes them
//             sequentially into the instruction RAM; holds the CPU in reset
//             until the HALT word has been written.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int                 NB_BITS   = C_NB_BITS,
  parameter int                 RAM_DEPTH = C_RAM_DEPTH,
  parameter logic [NB_BITS-1:0] HALT_WORD = C_HALT_WORD
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic [NB_BITS-1:0]   o_mem_data,
  output logic [RAM_DEPTH-1:0] o_mem_addr,
  output logic                 o_mem_we,
  output logic                 o_mem_ena,
  output logic                 o_cpu_rst,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic [RAM_DEPTH:0]   o_word_count
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [NB_BITS-9:0]     r_shift;      // first three bytes of the word
  logic [1:0]             r_byte_cnt;
  logic [NB_BITS-1:0]     r_word;
  logic [RAM_DEPTH-1:0]   r_addr;
  logic [RAM_DEPTH:0]     r_count;

  logic w_clear;
  logic w_shift;
  logic w_latch;
  logic w_addr_inc;
  logic w_count_inc;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and datapath control; a start pulse always beats a byte strobe
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_latch      = 1'b0;
    w_addr_inc   = 1'b0;
    w_count_inc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_LOAD;
          w_clear      = 1'b1;
        end
      end
      ST_LOAD: begin
        if (i_start) begin
          w_clear = 1'b1;
        end else if (i_rx_valid) begin
          if (r_byte_cnt == 2'd3) begin
            w_latch      = 1'b1;
            w_state_next = ST_WRITE;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // The write itself is issued by the output register regardless of
        // what happens here, so a restart only affects the following cycle.
        w_count_inc = 1'b1;
        if (i_start) begin
          w_state_next = ST_LOAD;
          w_clear      = 1'b1;
        end else if (r_word == HALT_WORD) begin
          w_state_next = ST_DONE;
        end else if (&r_addr) begin
          w_state_next = ST_ERROR;
        end else begin
          w_state_next = ST_LOAD;
          w_addr_inc   = 1'b1;
          // A byte arriving now is byte 0 of the next word
          w_shift      = i_rx_valid;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (i_start) begin
          w_state_next = ST_LOAD;
          w_clear      = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Byte assembly, address and word counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift    <= '0;
      r_byte_cnt <= 2'd0;
      r_word     <= '0;
      r_addr     <= '0;
      r_count    <= '0;
    end else if (w_clear) begin
      r_shift    <= '0;
      r_byte_cnt <= 2'd0;
      r_addr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_shift) begin
        r_shift    <= {r_shift[NB_BITS-17:0], i_rx_data};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_latch) begin
        r_word     <= {r_shift, i_rx_data};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_addr_inc)  r_addr  <= r_addr + {{(RAM_DEPTH-1){1'b0}}, 1'b1};
      if (w_count_inc) r_count <= r_count + {{RAM_DEPTH{1'b0}}, 1'b1};
    end
  end

  // Registered outputs, one cycle behind the internal state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mem_data   <= '0;
      o_mem_addr   <= '0;
      o_mem_we     <= 1'b0;
      o_mem_ena    <= 1'b0;
      o_cpu_rst    <= 1'b1;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_mem_data   <= r_word;
      o_mem_addr   <= r_addr;
      o_mem_we     <= (r_state == ST_WRITE);
      o_mem_ena    <= (r_state == ST_WRITE);
      o_cpu_rst    <= (r_state != ST_DONE);
      o_done       <= (r_state == ST_DONE);
      o_overflow   <= (r_state == ST_ERROR);
      o_word_count <= r_count;
    end
  end

endmodule

`default_nettype wire
